// File: rtl/x_multdiv_unit.sv
// x_multdiv_unit
//   Iterative signed multiply / divide unit sitting in the execute stage.
//   A mul or div decoded into the D/X latch starts an operation that runs
//   for exactly ITER cycles. Stall is held high meanwhile so upstream
//   latches keep their contents. The result is presented for one cycle
//   (data_ready) together with the destination register and exception status.
//
// Ports
//   clock          system clock, rising-edge active
//   clr            asynchronous active-high reset
//   data_operandA  rs after bypass (multiplicand / dividend)
//   data_operandB  rt after bypass (multiplier / divisor)
//   isMul, isDiv   D/X decode flags (mul wins when both are set)
//   NOP_dx         D/X bubble flag, blocks start
//   rd_dx          destination register of the D/X instruction
//   result         product low word or quotient (valid with data_ready)
//   data_ready     one-cycle completion pulse
//   rd_out         destination captured at start (valid with data_ready)
//   exception      overflow / divide-by-zero (valid with data_ready)
//   exc_rstatus    4 = mul exception, 5 = div exception, else 0
//   stall          hold pipeline upstream of X
//   busy           operation in progress (RUN)
module x_multdiv_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clock,
  input  logic             clr,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             isMul,
  input  logic             isDiv,
  input  logic             NOP_dx,
  input  logic [4:0]       rd_dx,
  output logic [WIDTH-1:0] result,
  output logic             data_ready,
  output logic [4:0]       rd_out,
  output logic             exception,
  output logic [31:0]      exc_rstatus,
  output logic             stall,
  output logic             busy
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_mcand;   // multiplicand magnitude, shifts left each step
  logic [WIDTH-1:0]   r_mplier;  // mul: multiplier magnitude (shifts right); div: divisor magnitude
  logic [2*WIDTH-1:0] r_acc;     // mul: product accumulator; div: low word is dividend/quotient
  logic [WIDTH-1:0]   r_rem;     // div partial remainder
  logic               r_sign;
  logic               r_is_mul;
  logic               r_dbz;
  logic [4:0]         r_rd;
  logic [WIDTH-1:0]   r_result;
  logic               r_exc;
  logic [31:0]        r_status;

  logic               w_start;
  logic               w_last;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [2*WIDTH-1:0] w_mul_acc;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_diff;
  logic               w_q_bit;
  logic [2*WIDTH-1:0] w_div_acc;
  logic [WIDTH-1:0]   w_div_rem;
  logic [2*WIDTH-1:0] w_acc_step;
  logic [2*WIDTH-1:0] w_prod;
  logic               w_ovf;
  logic [WIDTH-1:0]   w_quo;

  assign w_start = (isMul | isDiv) & ~NOP_dx & (r_state == S_IDLE) & ~clr;
  assign w_last  = (r_state == S_RUN) && (r_cnt == CW'(ITER - 1));

  // Magnitudes; the most negative value maps onto itself as an unsigned number.
  assign w_abs_a = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
  assign w_abs_b = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;

  // Shift-add multiply step.
  assign w_mul_acc = r_acc + (r_mplier[0] ? r_mcand : '0);

  // Restoring divide step: bring in the next dividend bit, try subtracting.
  assign w_rem_sh  = {r_rem, r_acc[WIDTH-1]};
  assign w_diff    = w_rem_sh - {1'b0, r_mplier};
  assign w_q_bit   = ~w_diff[WIDTH];
  assign w_div_rem = w_q_bit ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
  assign w_div_acc = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-2:0], w_q_bit};

  assign w_acc_step = r_is_mul ? w_mul_acc : w_div_acc;

  // Final sign fix-up, evaluated on the last step so DONE can present registers.
  assign w_prod = r_sign ? (~w_acc_step + 1'b1) : w_acc_step;
  assign w_ovf  = (w_prod[2*WIDTH-1:WIDTH] != {WIDTH{w_prod[WIDTH-1]}});
  assign w_quo  = r_sign ? (~w_acc_step[WIDTH-1:0] + 1'b1) : w_acc_step[WIDTH-1:0];

  // State register
  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_next = S_RUN;
      S_RUN:   if (w_last)  w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_sign   <= 1'b0;
      r_is_mul <= 1'b0;
      r_dbz    <= 1'b0;
      r_rd     <= '0;
      r_result <= '0;
      r_exc    <= 1'b0;
      r_status <= '0;
    end else begin
      if (w_start) begin
        r_cnt    <= '0;
        r_mcand  <= {{WIDTH{1'b0}}, w_abs_a};
        r_mplier <= w_abs_b;
        r_acc    <= isMul ? '0 : {{WIDTH{1'b0}}, w_abs_a};
        r_rem    <= '0;
        r_sign   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        r_is_mul <= isMul;
        r_dbz    <= ~isMul & (data_operandB == '0);
        r_rd     <= rd_dx;
      end else if (r_state == S_RUN) begin
        r_cnt <= r_cnt + 1'b1;
        r_acc <= w_acc_step;
        if (r_is_mul) begin
          r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
        end else begin
          r_rem <= w_div_rem;
        end
        if (w_last) begin
          if (r_is_mul) begin
            r_result <= w_prod[WIDTH-1:0];
            r_exc    <= w_ovf;
            r_status <= w_ovf ? 32'd4 : 32'd0;
          end else if (r_dbz) begin
            r_result <= '0;
            r_exc    <= 1'b1;
            r_status <= 32'd5;
          end else begin
            r_result <= w_quo;
            r_exc    <= 1'b0;
            r_status <= 32'd0;
          end
        end
      end
    end
  end

  assign result      = r_result;
  assign rd_out      = r_rd;
  assign exc_rstatus = r_status;
  assign data_ready  = (r_state == S_DONE);
  assign exception   = (r_state == S_DONE) & r_exc;
  assign busy        = (r_state == S_RUN);
  assign stall       = ~clr & (w_start | (r_state == S_RUN));

endmodule

// File: tb/tb_x_multdiv_unit.sv
module tb_x_multdiv_unit;

  logic        clock;
  logic        clr;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        isMul;
  logic        isDiv;
  logic        NOP_dx;
  logic [4:0]  rd_dx;
  logic [31:0] result;
  logic        data_ready;
  logic [4:0]  rd_out;
  logic        exception;
  logic [31:0] exc_rstatus;
  logic        stall;
  logic        busy;

  x_multdiv_unit #(.WIDTH(32), .ITER(32)) dut (
    .clock         (clock),
    .clr           (clr),
    .data_operandA (data_operandA),
    .data_operandB (data_operandB),
    .isMul         (isMul),
    .isDiv         (isDiv),
    .NOP_dx        (NOP_dx),
    .rd_dx         (rd_dx),
    .result        (result),
    .data_ready    (data_ready),
    .rd_out        (rd_out),
    .exception     (exception),
    .exc_rstatus   (exc_rstatus),
    .stall         (stall),
    .busy          (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        exc;
    logic [31:0] st;
    int          cyc;
  } exp_t;

  exp_t expq[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference model straight from the arithmetic rules.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic m, input logic [4:0] rd);
    exp_t e;
    longint p;
    int     qa, qb;
    e.rd = rd;
    e.cyc = 0;
    if (m) begin
      p = longint'($signed(a)) * longint'($signed(b));
      e.res = p[31:0];
      e.exc = (p != longint'($signed(p[31:0])));
      e.st  = e.exc ? 32'd4 : 32'd0;
    end else if (b == 32'd0) begin
      e.res = 32'd0; e.exc = 1'b1; e.st = 32'd5;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.res = 32'h8000_0000; e.exc = 1'b0; e.st = 32'd0;
    end else begin
      qa = $signed(a);
      qb = $signed(b);
      e.res = qa / qb;
      e.exc = 1'b0; e.st = 32'd0;
    end
    return e;
  endfunction

  // Monitor: any completion pulse is matched against the scoreboard.
  always @(negedge clock) begin
    if (!clr && data_ready) begin
      if (expq.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_ready: actual=1 required=0 result=0x%0h (cycle %0d)", result, cyc);
      end else begin
        exp_t e;
        e = expq.pop_front();
        chk("ready_cycle", 64'(cyc), 64'(e.cyc));
        chk("result", 64'(result), 64'(e.res));
        chk("rd_out", 64'(rd_out), 64'(e.rd));
        chk("exception", 64'(exception), 64'(e.exc));
        chk("exc_rstatus", 64'(exc_rstatus), 64'(e.st));
        $display("op done cycle=%0d result=0x%08h rd=%0d exc=%0b st=%0d", cyc, result, rd_out, exception, exc_rstatus);
      end
    end else if (!data_ready && exception) begin
      n_checks++;
      $display("FAIL exception_outside_done: actual=1 required=0 (cycle %0d)", cyc);
    end
  end

  // Called just after a rising edge; the issue cycle T is the current cycle.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic m,
                       input logic d, input logic nop, input logic [4:0] rd);
    logic st;
    int   t;
    exp_t e;
    st = (m | d) & ~nop;
    t  = cyc;
    data_operandA = a; data_operandB = b;
    isMul = m; isDiv = d; NOP_dx = nop; rd_dx = rd;
    $display("issue cycle=%0d a=0x%08h b=0x%08h mul=%0b div=%0b nop=%0b rd=%0d", t, a, b, m, d, nop, rd);
    if (st) begin
      e = model(a, b, m, rd);
      e.cyc = t + 33;
      expq.push_back(e);
    end
    @(negedge clock);
    chk("stall_at_T", 64'(stall), 64'(st));
    @(posedge clock); #1;
    isMul = 1'b0; isDiv = 1'b0; NOP_dx = 1'b0;
    data_operandA = $urandom; data_operandB = $urandom; rd_dx = 5'($urandom);
    if (st) begin
      for (int k = 1; k <= 32; k++) begin
        @(negedge clock);
        if (k == 1 || k == 32) begin
          chk("stall_run", 64'(stall), 64'd1);
          chk("busy_run", 64'(busy), 64'd1);
        end
      end
      @(negedge clock);
      chk("stall_done", 64'(stall), 64'd0);
      chk("busy_done", 64'(busy), 64'd0);
      @(posedge clock); #1;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'd0;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    clr = 1'b1;
    data_operandA = '0; data_operandB = '0;
    isMul = 1'b1; isDiv = 1'b0; NOP_dx = 1'b0; rd_dx = 5'd3;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(data_ready), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_rd", 64'(rd_out), 64'd0);
    chk("rst_status", 64'(exc_rstatus), 64'd0);
    isMul = 1'b0;
    @(posedge clock); #1;
    clr = 1'b0;
    @(posedge clock); #1;

    // Directed cases
    do_op(32'd7, 32'hFFFF_FFFA, 1'b1, 1'b0, 1'b0, 5'd5);
    do_op(-32'd7, 32'd2, 1'b0, 1'b1, 1'b0, 5'd6);
    do_op(32'd100, 32'd7, 1'b0, 1'b1, 1'b0, 5'd7);
    do_op(32'd5, 32'd0, 1'b0, 1'b1, 1'b0, 5'd8);
    do_op(32'h0001_0000, 32'h0001_0000, 1'b1, 1'b0, 1'b0, 5'd9);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 5'd10);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 5'd11);

    // Suppressed starts: bubble and no flags
    do_op(32'd3, 32'd3, 1'b1, 1'b0, 1'b1, 5'd12);
    do_op(32'd3, 32'd3, 1'b0, 1'b0, 1'b0, 5'd13);
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (k == 0 || k == 39) begin
        chk("idle_stall", 64'(stall), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
      end
    end
    @(posedge clock); #1;

    // Abort with clr at T+10
    data_operandA = 32'd9; data_operandB = 32'd9; isMul = 1'b1; rd_dx = 5'd14;
    $display("issue cycle=%0d a=0x%08h b=0x%08h mul=1 (to be aborted)", cyc, data_operandA, data_operandB);
    @(posedge clock); #1;
    isMul = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    chk("busy_before_abort", 64'(busy), 64'd1);
    clr = 1'b1;
    #1;
    chk("abort_stall", 64'(stall), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_ready", 64'(data_ready), 64'd0);
    @(posedge clock); #1;
    clr = 1'b0;
    repeat (30) @(posedge clock);
    #1;
    do_op(32'd3, 32'd4, 1'b1, 1'b0, 1'b0, 5'd15);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      logic m, d, nop;
      m   = 1'($urandom_range(0, 1));
      d   = m ? 1'($urandom_range(0, 1)) : 1'b1;
      nop = ($urandom_range(0, 9) == 0);
      do_op(pick(), pick(), m, d, nop, 5'($urandom));
    end

    repeat (5) @(posedge clock);
    #1;
    chk("scoreboard_empty", 64'(expq.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/x_multdiv_unit.md
Name: x_multdiv_unit

Overview:
- Iterative signed multiply/divide unit for the execute stage, directly downstream of the decode/execute pipeline latch.
- Consumes the latched mul/div decode flags, bypassed operands and destination register. Runs a fixed-latency 32-iteration operation and asserts stall so the upstream fetch, F/D and D/X latches hold.
- Presents the result, destination and exception status to the X/M latch for one cycle.

Parameters:
- WIDTH, 32, operand/result width.
- ITER, 32, iterations per operation; must equal WIDTH.

Ports:
- clock  input  1  single system clock; all state updates on rising edge.
- clr  input  1  asynchronous, active-high reset.
- data_operandA  input  WIDTH  rs value after bypass (dividend / multiplicand).
- data_operandB  input  WIDTH  rt value after bypass (divisor / multiplier).
- isMul  input  1  D/X latched mul flag.
- isDiv  input  1  D/X latched div flag.
- NOP_dx  input  1  D/X latched bubble flag; suppresses start.
- rd_dx  input  5  destination register of the D/X instruction.
- result  output  WIDTH  product low word or quotient; valid only while data_ready=1.
- data_ready  output  1  one-cycle completion pulse.
- rd_out  output  5  destination captured at start; valid with data_ready.
- exception  output  1  overflow or divide-by-zero flag; valid with data_ready.
- exc_rstatus  output  32  4 for mul exception, 5 for div exception, else 0; valid with data_ready.
- stall  output  1  hold pipeline upstream of X.
- busy  output  1  state is RUN.

Behaviour:
- Clock and reset: clock is the single clock. clr is asynchronous and active-high.
- While clr=1:
  - state=IDLE.
  - Counter, operand, accumulator and remainder registers are 0.
  - result, data_ready, rd_out, exception, exc_rstatus, busy and stall are all 0.
  - stall is gated low combinationally by clr.
- Start condition: start = (isMul | isDiv) & ~NOP_dx & (state==IDLE) & ~clr. Start is evaluated only in IDLE.
- Mode select: isMul=1 selects mul mode. If isMul and isDiv are both 1, mul takes priority.
- States:
  - IDLE: on start (cycle T), at the edge that ends T:
    - capture |A| and |B|, sign = A[31]^B[31], mode and rd_dx;
    - flag div-by-zero if B==0 in div mode;
    - counter := 0; go to RUN.
  - RUN, multiply: per cycle one shift-add step on magnitudes into a 64-bit accumulator.
  - RUN, divide: per cycle one restoring step producing one quotient bit.
  - RUN, counter: increments each cycle. After the step with counter==ITER-1, go to DONE. RUN therefore lasts exactly ITER cycles (T+1..T+32).
  - DONE (cycle T+33):
    - data_ready=1; result, rd_out, exception and exc_rstatus driven;
    - go to IDLE unconditionally at the next edge.
- Stall and latency:
  - stall = start | (state==RUN), i.e. high in cycles T..T+32.
  - stall is low in DONE, so the D/X latch advances past the consumed instruction. Start is not evaluated in DONE, so there is no re-trigger.
  - Fixed latency: data_ready at T+33 for every operation, including div-by-zero.
- Multiply arithmetic:
  - Signed two's complement. result = low 32 bits of the signed 64-bit product (sign applied by negating the magnitude product).
  - exception=1 when the 64-bit signed product differs from the sign-extension of its low word; then exc_rstatus=4 and result is the low word.
- Divide arithmetic:
  - Signed; quotient truncates toward zero; remainder discarded.
  - B==0: result=0, exception=1, exc_rstatus=5.
  - 0x80000000 / -1: result=0x80000000 (wrap), exception=0.
- Magnitudes: |0x80000000| = 0x80000000, treated as unsigned 32-bit.
- Outputs outside DONE: data_ready=0 and exception=0; other outputs hold their values and are don't-care.
- Back-to-back: a second mul/div entering D/X in the cycle after DONE starts in that IDLE cycle, giving a 34-cycle issue interval.
- Reset mid-operation: clr in RUN or DONE aborts immediately (asynchronous). No data_ready is produced and stall drops in the same cycle.
- Operand changes on data_operandA/B after T are ignored.

Test Plan:
- mul: A=7, B=-6 (0xFFFFFFFA), rd=5 → stall high T..T+32; at T+33 data_ready=1, result=0xFFFFFFD6, rd_out=5, exception=0.
- div: A=-7, B=2 → at T+33 result=0xFFFFFFFD, exception=0; a second div 100/7 issued next → result=14 at its own T'+33 with T'=T+34.
- div by zero: A=5, B=0 → at T+33 result=0, exception=1, exc_rstatus=5.
- mul overflow: A=0x00010000, B=0x00010000 → result=0, exception=1, exc_rstatus=4. Also 0x80000000/-1 → result=0x80000000, exception=0.
- NOP_dx=1 with isMul=1, and isMul=isDiv=0 → stall=0, state stays IDLE, no data_ready for 40 cycles.
- clr pulsed at T+10 of a mul → stall=0 and busy=0 immediately, no data_ready at T+33. A subsequent 3*4 completes with result=12 after 33 cycles.
